shift_normalizer: RTL

//  Multi-cycle normalizer: inverse of the barrel shifter. Given a 32-bit value, finds the shift

---
 rtl/shift_normalizer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/shift_normalizer.sv
// ============================================================================
// shift_normalizer
// ----------------------------------------------------------------------------
// Multi-cycle CLZ/CTZ unit. This is the inverse of the barrel shifter. It
// finds how far the first set bit sits from the MSB, giving the leading-zero
// count. When trailing-zero mode is built in and requested, it finds how far
// that bit sits from the LSB instead. It returns the count together with the
// value shifted by that amount.
//
// The unit scans one bit position per clock:
//   IDLE -> SCAN -> DONE -> IDLE
// A zero operand skips SCAN and goes straight to DONE with a count of WIDTH.
// In SCAN, a nonzero operand with N zeros takes N+1 clocks before the result
// appears.
//
// Configuration macro:
//   NORM_CTZ_EN  defined   : in_ctz is latched per request. 1 selects
//                            trailing-zero count and a right shift.
//                undefined : in_ctz is ignored and the unit always counts
//                            leading zeros. The ctz latch and the
//                            right-shift path are not built.
//
// Ports:
//   clk        in   1        single clock, rising edge
//   rst        in   1        asynchronous, active-high reset
//   in_valid   in   1        request valid
//   in_ready   out  1        unit idle; a request is taken on in_valid & in_ready
//   in_val     in   WIDTH    value to normalize
//   in_ctz     in   1        1 = count trailing zeros, 0 = count leading zeros
//   out_valid  out  1        result valid, held until out_ready
//   out_ready  in   1        consumer accepts the result
//   out_norm   out  WIDTH    normalized value
//   out_count  out  CW       zero count, 0..WIDTH (CW = $clog2(WIDTH)+1)
//   out_zero   out  1        operand was all zeros
// ============================================================================
module shift_normalizer #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_val,
    input  logic                   in_ctz,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_norm,
    output logic [$clog2(WIDTH):0] out_count,
    output logic                   out_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] norm_q, norm_d;
    logic [CW-1:0]    count_q, count_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             ctz_sel;
    logic             test_bit;

    assign accept = in_valid & in_ready;

`ifdef NORM_CTZ_EN
    // The direction is captured at accept. Later changes on in_ctz
    // cannot redirect a scan that is already in flight.
    logic ctz_q, ctz_d;

    always_comb begin
        ctz_d = ctz_q;
        if (accept) begin
            ctz_d = in_ctz;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctz_q <= 1'b0;
        end else begin
            ctz_q <= ctz_d;
        end
    end

    assign ctz_sel = ctz_q;
`else
    // Only leading-zero counting is built. in_ctz is deliberately left unused.
    logic ctz_unused;
    assign ctz_unused = in_ctz;
    assign ctz_sel    = 1'b0;
`endif

    // The scanned bit is the one the work register shifts toward.
    assign test_bit = ctz_sel ? work_q[0] : work_q[WIDTH-1];

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        norm_d  = norm_q;
        count_d = count_q;
        zero_d  = zero_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d = in_val;
                    cnt_d  = '0;
                    if (in_val == '0) begin
                        // Nothing to scan. Report a full-width count right away.
                        state_d = DONE;
                        norm_d  = '0;
                        count_d = CW'(WIDTH);
                        zero_d  = 1'b1;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end

            SCAN: begin
                if (test_bit) begin
                    // The work register is already normalized. Publish it.
                    state_d = DONE;
                    norm_d  = work_q;
                    count_d = cnt_q;
                    zero_d  = 1'b0;
                end else begin
                    // The operand is nonzero, so a set bit reaches the tested
                    // end within WIDTH-1 shifts. cnt_q therefore cannot pass
                    // WIDTH-1 here.
                    work_d = ctz_sel ? (work_q >> 1) : (work_q << 1);
                    cnt_d  = cnt_q + 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            norm_q  <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            norm_q  <= norm_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    // in_ready is gated by rst directly. This keeps it low for the whole
    // time reset is asserted, including the time before the first clock
    // edge.
    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE);
    assign out_norm  = norm_q;
    assign out_count = count_q;
    assign out_zero  = zero_q;

endmodule
